// File: rtl/jt1943_busarb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : jt1943_busarb_pkg
//  Brief   : Shared types and defaults for the 1943 object-DMA bus arbiter.
//  Revision: 1.0  initial release
// ============================================================================
package jt1943_busarb_pkg;

    // Arbiter states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2,
        ST_REL   = 2'd3
    } arb_state_t;

    // Clocks to wait for BUSAK before giving up on a request
    localparam logic [11:0] TIMEOUT_DEFAULT = 12'd4095;

    // Object RAM / DMA address width
    localparam int AW_DEFAULT = 13;

endpackage : jt1943_busarb_pkg
`default_nettype wire

// File: rtl/jt1943_busarb.sv
`default_nettype none
// ============================================================================
//  Module  : jt1943_busarb
//  Brief   : Arbitrates the object RAM between the Z80 and the object DMA
//            engine. Requests the CPU bus through BUSRQ/BUSAK, steers the
//            RAM address, latches DMA read data and generates the OKOUT
//            copy-permit strobe.
//  Revision: 1.0  initial release
// ============================================================================
module jt1943_busarb
    import jt1943_busarb_pkg::*;
#(
    parameter logic [11:0] TIMEOUT = TIMEOUT_DEFAULT,
    parameter int          AW      = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen6,
    input  logic          cpu_cen,
    // object engine side
    input  logic          bus_req,
    output logic          bus_ack,
    input  logic          blcnten,
    input  logic [AW-1:0] obj_AB,
    output logic [7:0]    obj_DB,
    output logic          OKOUT,
    // CPU side
    output logic          cpu_busrq_n,
    input  logic          cpu_busak_n,
    input  logic [AW-1:0] cpu_AB,
    input  logic          ram_cs,
    input  logic          okout_cs,
    input  logic          wr_n,
    // object RAM
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    // status
    output logic          req_timeout
);

    arb_state_t  state;
    logic [11:0] wait_cnt;
    logic        dma_rd;
    logic        okout_wr;

    // The DMA owns the RAM address only while granted and its counter is live
    assign dma_rd   = (state == ST_GRANT) && blcnten;
    assign okout_wr = cpu_cen && okout_cs && !wr_n;

    assign ram_addr = dma_rd ? obj_AB : cpu_AB;
    assign ram_we   = ram_cs && !wr_n && cpu_cen && (state != ST_GRANT);

    // Bus handshake FSM; BUSRQ and bus_ack are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= 12'd0;
            bus_ack     <= 1'b0;
            cpu_busrq_n <= 1'b1;
            req_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus_ack <= 1'b0;
                    // a request that never overlaps a cen6 cycle is ignored
                    if (cen6 && bus_req) begin
                        state       <= ST_REQ;
                        wait_cnt    <= 12'd0;
                        cpu_busrq_n <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (wait_cnt != TIMEOUT) begin
                        wait_cnt <= wait_cnt + 12'd1;
                    end
                    // acknowledge wins over a simultaneous drop of bus_req;
                    // bus_ack follows one clock later from the GRANT branch
                    if (cpu_cen && !cpu_busak_n) begin
                        state <= ST_GRANT;
                    end else if (!bus_req) begin
                        state       <= ST_REL;
                        cpu_busrq_n <= 1'b1;
                    end else if (wait_cnt == TIMEOUT) begin
                        state       <= ST_IDLE;
                        cpu_busrq_n <= 1'b1;
                        req_timeout <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!bus_req) begin
                        state       <= ST_REL;
                        cpu_busrq_n <= 1'b1;
                        bus_ack     <= 1'b0;
                    end else begin
                        bus_ack <= 1'b1;
                    end
                end
                ST_REL: begin
                    bus_ack <= 1'b0;
                    // wait for the CPU to actually take the bus back
                    if (cpu_cen && cpu_busak_n) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    bus_ack     <= 1'b0;
                    cpu_busrq_n <= 1'b1;
                end
            endcase
        end
    end

    // Latch RAM data for the DMA while it drives the address; hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            obj_DB <= 8'h00;
        end else if (dma_rd) begin
            obj_DB <= ram_dout;
        end
    end

    // OKOUT: a CPU write sets it, the next cen6 after the write clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            OKOUT <= 1'b0;
        end else if (okout_wr) begin
            OKOUT <= 1'b1;
        end else if (cen6) begin
            OKOUT <= 1'b0;
        end
    end

endmodule : jt1943_busarb
`default_nettype wire

// File: tb/tb_jt1943_busarb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_jt1943_busarb
//  Brief   : Self-checking bench for jt1943_busarb: directed scenarios plus a
//            randomized run compared against a behavioural bus-ownership model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_jt1943_busarb;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst, cen6, cpu_cen, bus_req, bus_ack, blcnten;
    logic [AW-1:0] obj_AB, cpu_AB, ram_addr;
    logic [7:0]    obj_DB, ram_dout;
    logic          OKOUT, cpu_busrq_n, cpu_busak_n;
    logic          ram_cs, okout_cs, wr_n, ram_we, req_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jt1943_busarb #(.TIMEOUT(12'd4095), .AW(AW)) dut (
        .clk(clk), .rst(rst), .cen6(cen6), .cpu_cen(cpu_cen),
        .bus_req(bus_req), .bus_ack(bus_ack), .blcnten(blcnten),
        .obj_AB(obj_AB), .obj_DB(obj_DB), .OKOUT(OKOUT),
        .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
        .cpu_AB(cpu_AB), .ram_cs(ram_cs), .okout_cs(okout_cs), .wr_n(wr_n),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout),
        .req_timeout(req_timeout)
    );

    // ------------------------------------------------------------------
    // Behavioural model: who holds the object bus
    // ------------------------------------------------------------------
    localparam int M_FREE = 0, M_ASKING = 1, M_OWNED = 2, M_GIVING_BACK = 3;
    int       m_holder;
    int       m_clocks_asking;
    bit       m_ack, m_rq_n, m_ok, m_to;
    logic [7:0] m_db;

    always @(posedge clk) begin
        int was;
        was = m_holder;
        if (rst) begin
            m_holder = M_FREE; m_clocks_asking = 0; m_ack = 0; m_rq_n = 1;
            m_ok = 0; m_to = 0; m_db = 8'h00;
        end else begin
            if (was == M_OWNED && blcnten) m_db = ram_dout;
            if (cpu_cen && okout_cs && !wr_n) m_ok = 1;
            else if (cen6) m_ok = 0;
            case (was)
                M_FREE: if (cen6 && bus_req) begin
                    m_holder = M_ASKING; m_clocks_asking = 0;
                end
                M_ASKING: begin
                    if (cpu_cen && !cpu_busak_n) m_holder = M_OWNED;
                    else if (!bus_req) m_holder = M_GIVING_BACK;
                    else if (m_clocks_asking + 1 >= 4096) begin
                        m_holder = M_FREE; m_to = 1;
                    end else m_clocks_asking++;
                end
                M_OWNED: if (!bus_req) m_holder = M_GIVING_BACK;
                default: if (cpu_cen && cpu_busak_n) m_holder = M_FREE;
            endcase
            m_ack  = (was == M_OWNED) && (m_holder == M_OWNED);
            m_rq_n = !(m_holder == M_ASKING || m_holder == M_OWNED);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checks inside)
    // ------------------------------------------------------------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_inputs();
        cen6 = 0; cpu_cen = 0; bus_req = 0; blcnten = 0; obj_AB = '0;
        cpu_AB = '0; cpu_busak_n = 1; ram_cs = 0; okout_cs = 0; wr_n = 1;
        ram_dout = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs(); rst = 1; step(); rst = 0;
    endtask

    // enter GRANT: one clock to REQ, one to GRANT
    task automatic go_grant();
        bus_req = 1; cen6 = 1; step(); cen6 = 0;
        cpu_busak_n = 0; cpu_cen = 1; step(); cpu_cen = 0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs(); rst = 1; step(2);
        checks++; if (bus_ack !== 1'b0) begin failures++; $display("FAIL rst_bus_ack got=%b exp=0", bus_ack); end
        checks++; if (cpu_busrq_n !== 1'b1) begin failures++; $display("FAIL rst_busrq_n got=%b exp=1", cpu_busrq_n); end
        checks++; if (OKOUT !== 1'b0) begin failures++; $display("FAIL rst_okout got=%b exp=0", OKOUT); end
        checks++; if (obj_DB !== 8'h00) begin failures++; $display("FAIL rst_obj_db got=%h exp=00", obj_DB); end
        checks++; if (req_timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", req_timeout); end
        rst = 0;
    endtask

    task automatic test_handshake();
        do_reset();
        bus_req = 1; cen6 = 1; step(); cen6 = 0;
        checks++; if (cpu_busrq_n !== 1'b0) begin failures++; $display("FAIL hs_busrq_asserted got=%b exp=0", cpu_busrq_n); end
        cpu_cen = 1; cpu_busak_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus_ack !== 1'b0 || cpu_busrq_n !== 1'b0) begin
                failures++; $display("FAIL hs_waiting ack=%b busrq_n=%b exp ack=0 busrq_n=0", bus_ack, cpu_busrq_n);
            end
        end
        cpu_busak_n = 0; step(); cpu_cen = 0;
        checks++; if (bus_ack !== 1'b0) begin failures++; $display("FAIL hs_ack_early got=%b exp=0", bus_ack); end
        step();
        checks++; if (bus_ack !== 1'b1) begin failures++; $display("FAIL hs_ack got=%b exp=1", bus_ack); end
        bus_req = 0; step();
        checks++; if (cpu_busrq_n !== 1'b1 || bus_ack !== 1'b0) begin
            failures++; $display("FAIL hs_release busrq_n=%b ack=%b exp 1/0", cpu_busrq_n, bus_ack);
        end
        // still releasing while BUSAK is low: a new request must not issue
        bus_req = 1; cen6 = 1; cpu_cen = 1; step();
        checks++; if (cpu_busrq_n !== 1'b1) begin failures++; $display("FAIL hs_rel_hold got=%b exp=1", cpu_busrq_n); end
        bus_req = 0; cen6 = 0; cpu_busak_n = 1; step();
        bus_req = 1; cen6 = 1; cpu_cen = 0; step(); cen6 = 0;
        checks++; if (cpu_busrq_n !== 1'b0) begin failures++; $display("FAIL hs_back_to_idle got=%b exp=0", cpu_busrq_n); end
    endtask

    task automatic test_dma_read();
        do_reset();
        go_grant();
        blcnten = 1; obj_AB = 13'h0A5; cpu_AB = 13'h1FF; ram_dout = 8'h3C;
        ram_cs = 1; wr_n = 0; cpu_cen = 1; #1;
        checks++; if (ram_addr !== 13'h0A5) begin failures++; $display("FAIL dma_addr got=%h exp=0a5", ram_addr); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL dma_we_blocked got=%b exp=0", ram_we); end
        step();
        checks++; if (obj_DB !== 8'h3C) begin failures++; $display("FAIL dma_data got=%h exp=3c", obj_DB); end
        blcnten = 0; ram_dout = 8'h55; #1;
        checks++; if (ram_addr !== 13'h1FF) begin failures++; $display("FAIL dma_cpu_addr got=%h exp=1ff", ram_addr); end
        step();
        checks++; if (obj_DB !== 8'h3C) begin failures++; $display("FAIL dma_hold got=%h exp=3c", obj_DB); end
        bus_req = 0; step(); #1;
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL dma_we_after got=%b exp=1", ram_we); end
        cpu_cen = 0; #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL dma_we_nocen got=%b exp=0", ram_we); end
        ram_cs = 0; wr_n = 1;
    endtask

    task automatic test_timeout();
        do_reset();
        bus_req = 1; cen6 = 1; step(); cen6 = 0; cpu_cen = 1; cpu_busak_n = 1;
        step(4095);
        checks++; if (cpu_busrq_n !== 1'b0 || req_timeout !== 1'b0) begin
            failures++; $display("FAIL to_before busrq_n=%b to=%b exp 0/0", cpu_busrq_n, req_timeout);
        end
        step();
        checks++; if (cpu_busrq_n !== 1'b1 || req_timeout !== 1'b1) begin
            failures++; $display("FAIL to_expire busrq_n=%b to=%b exp 1/1", cpu_busrq_n, req_timeout);
        end
        bus_req = 0; step(5);
        checks++; if (req_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", req_timeout); end
        do_reset();
        checks++; if (req_timeout !== 1'b0) begin failures++; $display("FAIL to_cleared got=%b exp=0", req_timeout); end
    endtask

    task automatic test_okout();
        int seen;
        do_reset();
        okout_cs = 1; wr_n = 0; cpu_cen = 1; step(); okout_cs = 0; wr_n = 1; cpu_cen = 0;
        checks++; if (OKOUT !== 1'b1) begin failures++; $display("FAIL ok_set got=%b exp=1", OKOUT); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cen6 = (i % 4 == 3); #1;
            if (cen6 && OKOUT) seen++;
            step();
        end
        cen6 = 0;
        checks++; if (seen !== 1) begin failures++; $display("FAIL ok_one_edge got=%0d exp=1", seen); end
        // rewrite while high, coinciding with a cen6: window restarts
        okout_cs = 1; wr_n = 0; cpu_cen = 1; step();
        cen6 = 1; step(); okout_cs = 0; wr_n = 1; cpu_cen = 0;
        checks++; if (OKOUT !== 1'b1) begin failures++; $display("FAIL ok_extend got=%b exp=1", OKOUT); end
        step();
        checks++; if (OKOUT !== 1'b0) begin failures++; $display("FAIL ok_clear got=%b exp=0", OKOUT); end
        cen6 = 0;
    endtask

    task automatic test_reset_in_grant();
        do_reset();
        go_grant();
        blcnten = 1; ram_dout = 8'h77; okout_cs = 1; wr_n = 0; cpu_cen = 1; step();
        okout_cs = 0; wr_n = 1; cpu_cen = 0;
        checks++; if (bus_ack !== 1'b1 || obj_DB !== 8'h77 || OKOUT !== 1'b1) begin
            failures++; $display("FAIL rg_setup ack=%b db=%h ok=%b exp 1/77/1", bus_ack, obj_DB, OKOUT);
        end
        rst = 1; step(); rst = 0;
        checks++; if (bus_ack !== 1'b0 || cpu_busrq_n !== 1'b1 || OKOUT !== 1'b0 || obj_DB !== 8'h00 || req_timeout !== 1'b0) begin
            failures++; $display("FAIL rg_outputs ack=%b busrq_n=%b ok=%b db=%h to=%b exp 0/1/0/00/0",
                                 bus_ack, cpu_busrq_n, OKOUT, obj_DB, req_timeout);
        end
        // BUSAK still low: from IDLE a new request issues (would not from REL)
        blcnten = 0; cen6 = 1; step(); cen6 = 0;
        checks++; if (cpu_busrq_n !== 1'b0) begin failures++; $display("FAIL rg_no_rel got=%b exp=0", cpu_busrq_n); end
    endtask

    task automatic test_abort();
        int acks;
        do_reset();
        bus_req = 1; cen6 = 1; step(); cen6 = 0;
        bus_req = 0; cpu_cen = 1; step();
        checks++; if (cpu_busrq_n !== 1'b1) begin failures++; $display("FAIL ab_release got=%b exp=1", cpu_busrq_n); end
        acks = 0; cpu_busak_n = 0; bus_req = 1; cen6 = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus_ack !== 1'b0 || cpu_busrq_n !== 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin failures++; $display("FAIL ab_no_ack got=%0d exp=0", acks); end
        cen6 = 0; bus_req = 0;
    endtask

    task automatic test_glitch();
        do_reset();
        bus_req = 1; step(); bus_req = 0; step();
        cen6 = 1; step(); cen6 = 0;
        checks++; if (cpu_busrq_n !== 1'b1) begin failures++; $display("FAIL gl_no_req got=%b exp=1", cpu_busrq_n); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 399) == 0);
            cen6     = ($urandom_range(0, 3) == 0);
            cpu_cen  = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) bus_req = ~bus_req;
            cpu_busak_n = ($urandom_range(0, 3) == 0) ? 1'($urandom) : m_rq_n;
            blcnten  = $urandom_range(0, 1);
            obj_AB   = AW'($urandom);
            cpu_AB   = AW'($urandom);
            ram_dout = 8'($urandom);
            ram_cs   = $urandom_range(0, 1);
            okout_cs = ($urandom_range(0, 15) == 0);
            wr_n     = $urandom_range(0, 1);
            #1;
            checks++;
            if (bus_ack !== m_ack || cpu_busrq_n !== m_rq_n || OKOUT !== m_ok || obj_DB !== m_db ||
                req_timeout !== m_to ||
                ram_addr !== ((m_holder == M_OWNED && blcnten) ? obj_AB : cpu_AB) ||
                ram_we !== (ram_cs && !wr_n && cpu_cen && m_holder != M_OWNED)) begin
                failures++;
                $display("FAIL rnd_cycle%0d ack=%b/%b busrq_n=%b/%b ok=%b/%b db=%h/%h to=%b/%b addr=%h we=%b (got/exp)",
                         i, bus_ack, m_ack, cpu_busrq_n, m_rq_n, OKOUT, m_ok, obj_DB, m_db,
                         req_timeout, m_to, ram_addr, ram_we);
            end
        end
        rst = 0;
    endtask

    initial begin
        idle_inputs(); rst = 1;
        test_reset();
        test_handshake();
        test_dma_read();
        test_timeout();
        test_okout();
        test_reset_in_grant();
        test_abort();
        test_glitch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule : tb_jt1943_busarb
`default_nettype wire
